// File: rtl/uart_rx_if.sv
// uart_rx_if: bundles baud select and received-byte status between uart_rx and its consumer.
//   baud_rate  [17:0] baud select driven by the consumer (9600/38400/115200/230400)
//   rx_data    [7:0]  last correctly received byte
//   rx_valid          one-cycle strobe when rx_data updates
//   frame_err         one-cycle strobe when a stop bit is sampled low
//   parity_err        one-cycle strobe on even-parity mismatch
//   rx_busy           high whenever the receiver is not idle
interface uart_rx_if;
  logic [17:0] baud_rate;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_err;
  logic        parity_err;
  logic        rx_busy;
  modport master (input baud_rate, output rx_data, rx_valid, frame_err, parity_err, rx_busy);
  modport slave  (output baud_rate, input rx_data, rx_valid, frame_err, parity_err, rx_busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling; optional even parity when UART_RX_PARITY_EN is defined.
//   clk_50m  50 MHz system clock
//   rst_n    asynchronous active-low reset
//   RX       asynchronous serial input, idle high
//   bus      uart_rx_if.master: baud_rate in; rx_data/rx_valid/frame_err/parity_err/rx_busy out
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk_50m,
  input  logic      rst_n,
  input  logic      RX,
  uart_rx_if.master bus
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PARITY;
`else
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic rx_s;
  logic [12:0] step_sel, step_q, step_d, half, cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic rx_valid_q, rx_valid_d, frame_err_q, frame_err_d;
  logic par_bad_q;
`ifdef UART_RX_PARITY_EN
  logic par_bad_d, parity_err_q, parity_err_d;
  assign bus.parity_err = parity_err_q;
`else
  assign par_bad_q = 1'b0;
  assign bus.parity_err = 1'b0;
`endif
  assign sync_d = {sync_q[SYNC_STAGES-2:0], RX};
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign half = step_q >> 1;
  assign step_sel = bus.baud_rate == 18'd9600   ? 13'd5208 :
                    bus.baud_rate == 18'd38400  ? 13'd1302 :
                    bus.baud_rate == 18'd115200 ? 13'd434  :
                    bus.baud_rate == 18'd230400 ? 13'd217  : 13'd0;
  assign bus.rx_data = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.rx_busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 13'd1;
    step_d = step_q;
    idx_d = idx_q;
    shreg_d = shreg_q;
    rx_data_d = rx_data_q;
    rx_valid_d = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // step is captured here so a baud change only affects the next frame
        if (!rx_s && step_sel != 13'd0) begin
          state_d = START;
          step_d = step_sel;
        end
      end
      START: if (cnt_q == half - 13'd1) begin
        cnt_d = '0;
        idx_d = '0;
        state_d = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt_q == step_q - 13'd1) begin
        cnt_d = '0;
        shreg_d = {rx_s, shreg_q[7:1]};
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = AFTER_DATA;
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == step_q - 13'd1) begin
        cnt_d = '0;
        par_bad_d = rx_s != ^shreg_q;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == step_q - 13'd1) begin
        cnt_d = '0;
        if (rx_s) begin
          // a parity error replaces the valid strobe and leaves rx_data untouched
          rx_valid_d = !par_bad_q;
          rx_data_d = par_bad_q ? rx_data_q : shreg_q;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d = BREAK;
        end
      end
      BREAK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      sync_q <= '1;
      state_q <= IDLE;
      cnt_q <= '0;
      step_q <= '0;
      idx_q <= '0;
      shreg_q <= '0;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      step_q <= step_d;
      idx_q <= idx_d;
      shreg_q <= shreg_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_50m or negedge rst_n)
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      parity_err_q <= parity_err_d;
    end
`endif
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Frame format: 8 data bits LSB first, 1 start bit, 1 stop bit; optional even parity.
- Bit timing comes from the same 18-bit baud_rate selector and 50 MHz clock as the transmitter.
- Sits between the external RXD pin and frame-parsing logic; delivers one byte per frame with a single-cycle valid strobe.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the RX input synchroniser (min 2).

Ports:
- clk_50m  input  1  system clock, 50 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- RX  input  1  serial line from pin; asynchronous; idle high.
- baud_rate  input  18  baud select: 9600/38400/115200/230400.
- rx_data  output  8  last correctly received byte.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- parity_err  output  1  one-cycle pulse on parity mismatch (see Optional Feature).
- rx_busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (async, rst_n low):
  - Synchroniser flops = 1; state = IDLE; counters = 0.
  - rx_data = 8'h00; rx_valid, frame_err, parity_err, rx_busy = 0.
- Bit period step (13-bit):
  - 9600 -> 5208; 38400 -> 1302; 115200 -> 434; 230400 -> 217; any other value -> 0.
  - half = step >> 1.
  - step is latched on the IDLE->START transition and held for the whole frame; baud_rate changes mid-frame take effect on the next frame.
  - With step = 0 at detection time, the block stays in IDLE and ignores RX.
- rx_s is the output of the SYNC_STAGES synchroniser. All decisions use rx_s only.
- Bit counter cnt (13-bit): cleared on every state change; otherwise increments each clock.
- State machine:
  - IDLE: when rx_s == 0 and step != 0 -> START, cnt = 0, rx_busy = 1.
  - START: at cnt == half-1, sample rx_s.
    - 0 -> DATA, bit_idx = 0.
    - 1 -> false start, back to IDLE; no output pulses.
  - DATA: at cnt == step-1, shift in rx_s: shreg = {rx_s, shreg[7:1]}.
    - bit_idx increments on each sample.
    - After bit_idx 7 -> STOP (or PARITY if the feature is enabled).
  - STOP: at cnt == step-1, sample rx_s.
    - 1 -> rx_data <= shreg, rx_valid = 1 for exactly one cycle (unless a parity error is flagged), -> IDLE.
    - 0 -> frame_err = 1 for one cycle, rx_data unchanged, -> BREAK.
  - BREAK: wait until rx_s == 1, then -> IDLE. A held-low line (break) yields exactly one frame_err.
- rx_busy is low only in IDLE.
- Samples fall mid-bit. Latency from the RX falling edge to the rx_valid rising edge = SYNC_STAGES + half + 9*step + 1 cycles (no parity).
- Back-to-back frames:
  - A new start bit present during STOP→IDLE is detected on the first IDLE cycle.
  - No dead time is added beyond one cycle.
- Output timing: rx_valid, frame_err and parity_err are registered, mutually exclusive, and never high for two consecutive cycles.
- Reset mid-frame: all state is discarded; no pulse is emitted for the partial frame after release.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - A PARITY state is inserted after DATA. At cnt == step-1 it samples the parity bit, then -> STOP.
  - Even parity: the expected bit equals ^shreg.
  - On mismatch with stop bit high: parity_err pulses one cycle in place of rx_valid, and rx_data is unchanged.
  - If the stop bit is low: only frame_err pulses.
  - Latency grows by one step.
- Undefined: no PARITY state; parity_err tied 0.

Test Plan:
- 115200, RX sends 0x55 -> rx_data = 8'h55, rx_valid high 1 cycle at 2+217+9*434+1 = 4126 cycles after the start edge (±1); frame_err = 0.
- 9600, back-to-back 0xA5 then 0x3C with no idle gap -> two rx_valid pulses, 52080 ±2 cycles apart; rx_data = 8'hA5 then 8'h3C.
- 115200, RX low for 100 cycles then high -> false start; no pulses; rx_busy returns to 0 at cnt == 216 of START.
- 38400, frame 0xF0 with stop bit 0, then RX held low 20000 cycles -> exactly one frame_err, no rx_valid, rx_data holds its previous value, rx_busy stays high until RX rises.
- baud_rate = 12345, RX sends 0x81 -> no pulses, rx_busy stays 0. Switch baud_rate to 230400 mid-frame of a 9600 frame -> that frame is still decoded at 9600.
- rst_n pulsed low at data bit 4 of a 115200 frame -> outputs reset to 0 immediately. The remainder of the frame produces no rx_valid. The next clean frame 0x7E -> rx_data = 8'h7E. With UART_RX_PARITY_EN, 0x7E with parity bit 1 -> parity_err pulse, no rx_valid.
